// File: rtl/fft16_frame_ctrl.sv
// fft16_frame_ctrl: frame sequencer for a 16-point pipelined FFT core.
// Define FFT16_CTRL_SCALE_EN to divide streamed results by 16.
module fft16_frame_ctrl #(
  parameter int DW  = 16,
  parameter int LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_re,
  input  logic [DW-1:0]    s_im,
  output logic [16*DW-1:0] core_xr,
  output logic [16*DW-1:0] core_xi,
  input  logic [16*DW-1:0] core_yr,
  input  logic [16*DW-1:0] core_yi,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_re,
  output logic [DW-1:0]    m_im,
  output logic [3:0]       m_idx,
  output logic             m_last,
  output logic             busy
);

  typedef enum logic {
    FILL,
    FULL
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       fill_cnt_q, fill_cnt_d;
  logic [16*DW-1:0] ld_re_q, ld_re_d;
  logic [16*DW-1:0] ld_im_q, ld_im_d;
  logic [LAT-1:0]   vpipe_q, vpipe_d;
  logic [16*DW-1:0] buf_re_q [2];
  logic [16*DW-1:0] buf_re_d [2];
  logic [16*DW-1:0] buf_im_q [2];
  logic [16*DW-1:0] buf_im_d [2];
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [3:0]       rd_idx_q, rd_idx_d;
  logic [1:0]       outst_q, outst_d;

  logic             s_fire;
  logic             m_fire;
  logic             launch;
  logic             capture;
  logic             last_fire;
  logic [DW-1:0]    rd_re;
  logic [DW-1:0]    rd_im;

  // rst_n gate keeps s_ready low for the whole reset window
  assign s_ready   = (state_q == FILL) && rst_n;
  assign s_fire    = s_valid && s_ready;
  assign m_valid   = full_q[rd_sel_q];
  assign m_fire    = m_valid && m_ready;
  assign last_fire = m_fire && (rd_idx_q == 4'd15);
  assign launch    = (state_q == FULL)
                  && (outst_q != 2'd2);
  assign capture   = vpipe_q[LAT-1];

  assign core_xr = ld_re_q;
  assign core_xi = ld_im_q;

  assign rd_re  = buf_re_q[rd_sel_q][rd_idx_q*DW +: DW];
  assign rd_im  = buf_im_q[rd_sel_q][rd_idx_q*DW +: DW];
  assign m_idx  = rd_idx_q;
  assign m_last = (rd_idx_q == 4'd15);

`ifdef FFT16_CTRL_SCALE_EN
  assign m_re = $signed(rd_re) >>> 4;
  assign m_im = $signed(rd_im) >>> 4;
`else
  assign m_re = rd_re;
  assign m_im = rd_im;
`endif

  assign busy = (fill_cnt_q != 5'd0)
             || (outst_q != 2'd0);

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    ld_re_d    = ld_re_q;
    ld_im_d    = ld_im_q;
    unique case (state_q)
      FILL: begin
        if (s_fire) begin
          ld_re_d[fill_cnt_q[3:0]*DW +: DW] = s_re;
          ld_im_d[fill_cnt_q[3:0]*DW +: DW] = s_im;
          fill_cnt_d = fill_cnt_q + 5'd1;
          if (fill_cnt_q == 5'd15) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (launch) begin
          fill_cnt_d = 5'd0;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    vpipe_d  = LAT'({vpipe_q, launch});
    buf_re_d = buf_re_q;
    buf_im_d = buf_im_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    rd_idx_d = rd_idx_q;
    outst_d  = outst_q;
    // drain clears rd slot, capture fills wr slot; never the same
    if (m_fire) begin
      rd_idx_d = rd_idx_q + 4'd1;
      if (last_fire) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d = ~rd_sel_q;
      end
    end
    if (capture) begin
      buf_re_d[wr_sel_q] = core_yr;
      buf_im_d[wr_sel_q] = core_yi;
      full_d[wr_sel_q]   = 1'b1;
      wr_sel_d = ~wr_sel_q;
    end
    if (launch && !last_fire) begin
      outst_d = outst_q + 2'd1;
    end else if (!launch && last_fire) begin
      outst_d = outst_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      ld_re_q    <= '0;
      ld_im_q    <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      ld_re_q    <= ld_re_d;
      ld_im_q    <= ld_im_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q  <= '0;
      buf_re_q <= '{default: '0};
      buf_im_q <= '{default: '0};
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_idx_q <= '0;
      outst_q  <= '0;
    end else begin
      vpipe_q  <= vpipe_d;
      buf_re_q <= buf_re_d;
      buf_im_q <= buf_im_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      rd_idx_q <= rd_idx_d;
      outst_q  <= outst_d;
    end
  end

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// tb_fft16_frame_ctrl: random and directed checks of the FFT frame
// controller against a behavioural core (DFT or identity) and queues.
module tb_fft16_frame_ctrl;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DW-1:0]    s_re = '0;
  logic [DW-1:0]    s_im = '0;
  logic [16*DW-1:0] core_xr, core_xi;
  logic [16*DW-1:0] core_yr, core_yi;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW-1:0]    m_re, m_im;
  logic [3:0]       m_idx;
  logic             m_last;
  logic             busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  fft16_frame_ctrl #(.DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im),
    .core_xr(core_xr), .core_xi(core_xi),
    .core_yr(core_yr), .core_yi(core_yi),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_last(m_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural core: LAT register stages of DFT or identity
  bit dft_mode = 1'b1;
  logic [16*DW-1:0] pr [LAT];
  logic [16*DW-1:0] pi [LAT];

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic void dft(
    input  logic [16*DW-1:0] xr, xi,
    output logic [16*DW-1:0] yr, yi);
    real sr, si, a, c, s;
    yr = '0;
    yi = '0;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        a = 2.0 * 3.141592653589793 * k * n / 16.0;
        c = $cos(a);
        s = $sin(a);
        sr += $itor($signed(xr[n*DW +: DW])) * c
            + $itor($signed(xi[n*DW +: DW])) * s;
        si += $itor($signed(xi[n*DW +: DW])) * c
            - $itor($signed(xr[n*DW +: DW])) * s;
      end
      yr[k*DW +: DW] = DW'(rnd(sr));
      yi[k*DW +: DW] = DW'(rnd(si));
    end
  endfunction

  always @(posedge clk) begin : core_model
    logic [16*DW-1:0] fr, fi;
    if (dft_mode) dft(core_xr, core_xi, fr, fi);
    else begin
      fr = core_xr;
      fi = core_xi;
    end
    pr[0] <= fr;
    pi[0] <= fi;
    for (int i = 1; i < LAT; i++) begin
      pr[i] <= pr[i-1];
      pi[i] <= pi[i-1];
    end
  end

  assign core_yr = pr[LAT-1];
  assign core_yi = pi[LAT-1];

  function automatic logic [DW-1:0] scl(input logic [DW-1:0] v);
`ifdef FFT16_CTRL_SCALE_EN
    return $signed(v) >>> 4;
`else
    return v;
`endif
  endfunction

  // stimulus and observation queues
  logic [DW-1:0] in_re[$], in_im[$];
  logic [DW-1:0] o_re[$], o_im[$];
  logic [3:0]    o_idx[$];
  logic          o_last[$];
  int            in_ptr;
  int            first_v;
  int            x15_cyc;
  bit            stall_prev;
  logic [DW-1:0] p_re, p_im;
  logic [3:0]    p_idx;
  logic          p_last;

  task automatic clear_q();
    in_re.delete();
    in_im.delete();
    o_re.delete();
    o_im.delete();
    o_idx.delete();
    o_last.delete();
    in_ptr     = 0;
    first_v    = -1;
    x15_cyc    = -1;
    stall_prev = 1'b0;
  endtask

  task automatic step(input bit send, input bit rdy);
    s_valid = send && (in_ptr < in_re.size());
    if (s_valid) begin
      s_re = in_re[in_ptr];
      s_im = in_im[in_ptr];
    end
    m_ready = rdy;
    #1;
    if (m_valid && first_v < 0) first_v = cyc;
    if (s_valid && s_ready) begin
      if (in_ptr % 16 == 15) x15_cyc = cyc;
      in_ptr++;
    end
    if (m_valid && m_ready) begin
      o_re.push_back(m_re);
      o_im.push_back(m_im);
      o_idx.push_back(m_idx);
      o_last.push_back(m_last);
    end
    stall_prev = m_valid && !m_ready;
    p_re   = m_re;
    p_im   = m_im;
    p_idx  = m_idx;
    p_last = m_last;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input string tag);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    tests++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s rst ctl: s_ready=%b m_valid=%b busy=%b req 0/0/0",
               tag, s_ready, m_valid, busy);
    end
    tests++;
    if (m_re !== '0 || m_im !== '0 || m_idx !== 4'd0
        || m_last !== 1'b0 || core_xr !== '0 || core_xi !== '0) begin
      fails++;
      $display("FAIL %s rst data: m_re=%0h m_im=%0h idx=%0d last=%b req zero",
               tag, m_re, m_im, m_idx, m_last);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s release s_ready: got %b req 1", tag, s_ready);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    apply_reset("reset");
    tests++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset idle: busy=%b m_valid=%b req 0/0", busy, m_valid);
    end
  endtask

  task automatic run_frame(input string tag,
                           input logic [DW-1:0] xr [16],
                           input logic [DW-1:0] er [16]);
    int guard;
    clear_q();
    for (int i = 0; i < 16; i++) begin
      in_re.push_back(xr[i]);
      in_im.push_back('0);
    end
    guard = 0;
    while (o_re.size() < 16 && guard < 200) begin
      step(1'b1, 1'b1);
      guard++;
    end
    tests++;
    if (o_re.size() != 16) begin
      fails++;
      $display("FAIL %s count: got %0d req 16", tag, o_re.size());
    end
    for (int k = 0; k < o_re.size(); k++) begin
      tests++;
      if (o_re[k] !== scl(er[k]) || o_im[k] !== '0
          || o_idx[k] !== 4'(k) || o_last[k] !== (k == 15)) begin
        fails++;
        $display("FAIL %s bin%0d: got (%0d,%0d) idx %0d last %b req (%0d,0) idx %0d last %b",
                 tag, k, $signed(o_re[k]), $signed(o_im[k]), o_idx[k],
                 o_last[k], $signed(scl(er[k])), k, (k == 15));
      end
    end
    tests++;
    if (first_v != x15_cyc + 2 + LAT) begin
      fails++;
      $display("FAIL %s latency: got %0d req %0d",
               tag, first_v - x15_cyc, 2 + LAT);
    end
  endtask

  task automatic test_impulse();
    logic [DW-1:0] xr [16];
    logic [DW-1:0] er [16];
    dft_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xr[i] = (i == 0) ? DW'(1000) : '0;
      er[i] = DW'(1000);
    end
    run_frame("impulse", xr, er);
  endtask

  task automatic test_dc();
    logic [DW-1:0] xr [16];
    logic [DW-1:0] er [16];
    dft_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xr[i] = DW'(100);
      er[i] = (i == 0) ? DW'(1600) : '0;
    end
    run_frame("dc", xr, er);
  endtask

  task automatic test_backpressure();
    int guard;
    dft_mode = 1'b0;
    clear_q();
    for (int i = 0; i < 48; i++) begin
      in_re.push_back(DW'($urandom));
      in_im.push_back(DW'($urandom));
    end
    repeat (100) step(1'b1, 1'b0);
    tests++;
    if (in_ptr != 48 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp hold: accepted %0d s_ready %b req 48/0", in_ptr, s_ready);
    end
    tests++;
    if (m_valid !== 1'b1 || busy !== 1'b1 || o_re.size() != 0) begin
      fails++;
      $display("FAIL bp stall: m_valid %b busy %b out %0d req 1/1/0",
               m_valid, busy, o_re.size());
    end
    tests++;
    if (dut.full_q !== 2'b11 || dut.vpipe_q !== '0) begin
      fails++;
      $display("FAIL bp slots: full %b vpipe %b req 11/0",
               dut.full_q, dut.vpipe_q);
    end
    guard = 0;
    while (o_re.size() < 48 && guard < 300) begin
      step(1'b0, 1'b1);
      guard++;
    end
    tests++;
    if (o_re.size() != 48) begin
      fails++;
      $display("FAIL bp drain count: got %0d req 48", o_re.size());
    end
    for (int i = 0; i < o_re.size(); i++) begin
      tests++;
      if (o_re[i] !== scl(in_re[i]) || o_im[i] !== scl(in_im[i])
          || o_idx[i] !== 4'(i % 16)) begin
        fails++;
        $display("FAIL bp data%0d: got (%0h,%0h) idx %0d req (%0h,%0h) idx %0d",
                 i, o_re[i], o_im[i], o_idx[i],
                 scl(in_re[i]), scl(in_im[i]), i % 16);
      end
    end
    repeat (3) step(1'b0, 1'b1);
    tests++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp idle: busy %b m_valid %b req 0/0", busy, m_valid);
    end
  endtask

  task automatic test_random();
    int guard;
    int bad_stall;
    int bad_outst;
    dft_mode = 1'b0;
    clear_q();
    for (int i = 0; i < 320; i++) begin
      in_re.push_back(DW'($urandom));
      in_im.push_back(DW'($urandom));
    end
    guard = 0;
    bad_stall = 0;
    bad_outst = 0;
    while (o_re.size() < 320 && guard < 6000) begin
      if (stall_prev) begin
        tests++;
        if (m_valid !== 1'b1 || m_re !== p_re || m_im !== p_im
            || m_idx !== p_idx || m_last !== p_last) begin
          fails++;
          bad_stall++;
          if (bad_stall < 5)
            $display("FAIL rnd stable: idx %0d->%0d re %0h->%0h valid %b",
                     p_idx, m_idx, p_re, m_re, m_valid);
        end
      end
      tests++;
      if (dut.outst_q > 2'd2) begin
        fails++;
        bad_outst++;
        if (bad_outst < 5)
          $display("FAIL rnd outstanding: got %0d req <=2", dut.outst_q);
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      guard++;
    end
    tests++;
    if (o_re.size() != 320) begin
      fails++;
      $display("FAIL rnd count: got %0d req 320", o_re.size());
    end
    for (int i = 0; i < o_re.size(); i++) begin
      tests++;
      if (o_re[i] !== scl(in_re[i]) || o_im[i] !== scl(in_im[i])
          || o_idx[i] !== 4'(i % 16)
          || o_last[i] !== (i % 16 == 15)) begin
        fails++;
        $display("FAIL rnd data%0d: got (%0h,%0h) idx %0d req (%0h,%0h) idx %0d",
                 i, o_re[i], o_im[i], o_idx[i],
                 scl(in_re[i]), scl(in_im[i]), i % 16);
      end
    end
  endtask

  task automatic quiet_check(input string tag);
    o_re.delete();
    repeat (30) step(1'b0, 1'b1);
    tests++;
    if (o_re.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s stale: got %0d outputs busy %b req 0/0",
               tag, o_re.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    dft_mode = 1'b0;
    clear_q();
    for (int i = 0; i < 20; i++) begin
      in_re.push_back(DW'($urandom));
      in_im.push_back(DW'($urandom));
    end
    repeat (7) step(1'b1, 1'b1);
    apply_reset("midfill");
    quiet_check("midfill");

    clear_q();
    for (int i = 0; i < 16; i++) begin
      in_re.push_back(DW'($urandom));
      in_im.push_back(DW'($urandom));
    end
    repeat (16) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    apply_reset("inflight");
    quiet_check("inflight");

    clear_q();
    for (int i = 0; i < 16; i++) begin
      in_re.push_back(DW'($urandom));
      in_im.push_back(DW'($urandom));
    end
    guard = 0;
    while (o_re.size() < 5 && guard < 200) begin
      step(1'b1, 1'b1);
      guard++;
    end
    tests++;
    if (o_re.size() != 5) begin
      fails++;
      $display("FAIL middrain start: got %0d req 5", o_re.size());
    end
    apply_reset("middrain");
    quiet_check("middrain");

    clear_q();
    for (int i = 0; i < 16; i++) begin
      in_re.push_back(DW'($urandom));
      in_im.push_back(DW'($urandom));
    end
    guard = 0;
    while (o_re.size() < 16 && guard < 200) begin
      step(1'b1, 1'b1);
      guard++;
    end
    tests++;
    if (o_re.size() != 16) begin
      fails++;
      $display("FAIL post-reset count: got %0d req 16", o_re.size());
    end
    for (int i = 0; i < o_re.size(); i++) begin
      tests++;
      if (o_re[i] !== scl(in_re[i]) || o_im[i] !== scl(in_im[i])) begin
        fails++;
        $display("FAIL post-reset data%0d: got (%0h,%0h) req (%0h,%0h)",
                 i, o_re[i], o_im[i], scl(in_re[i]), scl(in_im[i]));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pr[i] = '0;
      pi[i] = '0;
    end
    test_reset();
    test_impulse();
    test_dc();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
